// File: rtl/serial_demux8.sv
// serial_demux8: bit-serial to word-parallel demultiplexer.
// Each accepted serial bit lands in the word position given by a slot counter.
// Completed words are presented on a valid/ready output register.
module serial_demux8 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [SEL_W-1:0] slot,
    output logic             sync_err
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

    logic [SEL_W-1:0] slot_q,       slot_d;
    logic [WIDTH-1:0] asm_q,        asm_d;
    logic [WIDTH-1:0] dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             sync_err_q,   sync_err_d;

    logic             accept;
    logic             complete;
    logic [SEL_W-1:0] eff_slot;

    // Input handshake: only the completing bit stalls, and only while an
    // unconsumed word is still held on the output.
    always_comb begin
        din_ready = !((slot_q == LAST_SLOT) && dout_valid_q && !dout_ready);
        accept    = din_valid && din_ready;
        eff_slot  = din_sof ? '0 : slot_q;
        complete  = accept && (eff_slot == LAST_SLOT);
    end

    // Next-state: slot advance, bit steering, output load/consume, sticky error.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path through
        // this block leaves it unassigned, which would infer a latch.
        slot_d       = slot_q;
        asm_d        = asm_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        sync_err_d   = sync_err_q;

        // Consumption first; a same-edge completion below overrides it.
        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (accept) begin
            if (din_sof) begin
                // SOF restarts assembly; any partial word is dropped.
                asm_d = '0;
                if (slot_q != '0) begin
                    sync_err_d = 1'b1;
                end
            end
            asm_d[eff_slot] = din;
            slot_d          = eff_slot + 1'b1;  // wraps mod WIDTH
            if (complete) begin
                dout_d       = asm_d;           // includes the bit just taken
                dout_valid_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same pre-edge values.
        if (rst) begin
            // NOTE: the assembly and output registers are reset too; they are
            // small flop arrays, not memories, and reset must clear dout.
            slot_q       <= '0;
            asm_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            asm_q        <= asm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign sync_err   = sync_err_q;

endmodule

// File: doc/serial_demux8.md
Name: serial_demux8

Overview:
- Serial-to-parallel demultiplexer. It is the receive-side counterpart of the 8:1 select mux.
- A 3-bit slot counter walks slots 0..7. Each accepted serial bit is steered into word bit position equal to the current slot.
- A completed word is presented on a valid/ready output register.
- Sits between a bit-serial link and byte-wide datapath logic.

Parameters:
- WIDTH, 8, word width; power of two, >= 2.
- SEL_W, 3, slot counter width; must equal $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- din_sof  input  1  start-of-word marker, qualified by din_valid; forces this bit into slot 0.
- din_ready  output  1  block can accept a bit this cycle.
- dout  output  WIDTH  assembled word; bit i = bit received in slot i (LSB-first).
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  downstream accepts dout.
- slot  output  SEL_W  slot index the next accepted non-SOF bit will fill.
- sync_err  output  1  sticky flag: SOF seen while a word was partially assembled.

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: slot=0, assembly register=0, dout=0, dout_valid=0, sync_err=0.
- Reset mid-word discards the partial word and any held output. The next accepted bit fills slot 0.
- Accept condition: din_valid && din_ready.
- Effective slot for an accepted bit: 0 if din_sof=1, else the current slot. The bit is written to assembly[effective slot].
- Slot update after acceptance: slot <= (effective slot + 1) mod WIDTH. Wrap 7 -> 0 is normal.
- Completion: the accepted bit's effective slot = WIDTH-1. On that same edge:
  - dout <= assembled word, including the bit just received.
  - dout_valid <= 1.
  - Latency is 1 cycle: dout_valid is visible in the cycle after the last bit is accepted.
- Output handshake:
  - A word is consumed on a cycle where dout_valid && dout_ready.
  - While dout_valid=1 && dout_ready=0, dout stays stable.
  - dout_valid falls after consumption unless a new word completes on the same edge. In that case dout loads the new word and dout_valid stays 1, with no bubble.
- Backpressure: din_ready = !(slot==WIDTH-1 && dout_valid && !dout_ready).
  - This is combinational from dout_ready and independent of din_sof.
  - Slots 0..WIDTH-2 keep filling while the output is held. Only the completing bit stalls.
- No gaps required: din_valid=0 cycles leave slot and assembly unchanged.
- SOF handling:
  - din_sof accepted with current slot != 0: the partial word is discarded, the bit goes to slot 0, slot becomes 1, and sync_err <= 1.
  - din_sof at slot 0: normal operation, no error.
  - din_sof without din_valid is ignored.
- sync_err stays high until rst. It does not affect data flow.
- Unwritten assembly bits never reach dout, because every slot is rewritten before completion.
- No combinational path from din to any output. din_ready is the only combinational output, and it depends only on registered state and dout_ready.

Test Plan:
1. Bits 0,1,0,1,0,1,0,1 (LSB-first), din_valid continuous, dout_ready=1 -> slot steps 0..7 then wraps to 0; dout=8'hAA with a single-cycle dout_valid pulse the cycle after the 8th bit is accepted; din_ready=1 throughout.
2. Back-to-back words 8'h55 then 8'hF0 with no idle cycles, dout_ready=1 -> two single-cycle dout_valid pulses exactly 8 cycles apart; values 8'h55 then 8'hF0.
3. Word 8'h3C completed with dout_ready=0, then 8'hC3 streamed in:
   - dout holds 8'h3C.
   - Bits for slots 0..6 are accepted.
   - din_ready=0 at slot 7 and the bit is held.
   - Raise dout_ready -> 8'h3C consumed, the 8th bit is accepted on that edge, and dout=8'hC3 with dout_valid staying 1.
4. Three bits, then din_sof=1 with bit 1 and seven more bits forming 8'h81 -> sync_err=1 (sticky), partial discarded, dout=8'h81.
5. rst asserted for 1 cycle at slot 5, then 8'hA5 streamed in -> after reset slot=0, dout_valid=0, sync_err=0, dout=0; then dout=8'hA5.
6. 8'h96 delivered with random din_valid gaps of 0-3 cycles -> slot advances only on accepted bits; dout=8'h96, single pulse.
